// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//    8N1 UART transmitter with an integrated baud-rate generator.
//    A one-cycle `en` while idle captures `data_in` and sends a frame on `tx`:
//    one start bit (0), eight data bits LSB first, one stop bit (1).
//    Every bit lasts DIV = CLK_FREQ / BAUD clock cycles.
//
// Parameters
//    CLK_FREQ  system clock frequency in Hz
//    BAUD      serial bit rate in bits/s
//
// Ports
//    clk        in   system clock, all logic on the rising edge
//    rst        in   synchronous active-high reset, abandons any frame
//    en         in   transmit request, acted on only while idle
//    data_in    in   byte captured on the accepting edge
//    tx         out  serial line, idles high (registered)
//    busy       out  high from the accepting edge to the end of the stop bit
//    baud_tick  out  one-cycle pulse in the last cycle of each bit (registered)
// ---------------------------------------------------------------------------
module uart_tx_core #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       baud_tick
);

   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // A divider below 2 would make every bit a single tick and break the
   // "counter cleared on accept" timing, so refuse to build.
   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_core: CLK_FREQ / BAUD must be at least 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       idx_q,   idx_d;
   logic             tx_q,    tx_d;
   logic             busy_q,  busy_d;
   logic             tick_q,  tick_d;

   // Baud counter: parked at zero while idle so the start bit, which begins
   // at the accepting edge, lasts exactly DIV cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE) begin
         cnt_d = CNT_ZERO;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = CNT_ZERO;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Frame sequencer: next state, shift register, bit index and line level.
   // The registered tick marks the last cycle of a bit, so every transition
   // below happens on the first edge of the following bit.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (en) begin
               shift_d = data_in;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_q) begin
               tx_d    = shift_q[0];
               idx_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_q) begin
               if (idx_q != 3'd7) begin
                  // Shift first, then present the new LSB as the next bit.
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_DATA;
               end else begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (tick_q) begin
               // en is not looked at here, which gives the one idle cycle
               // between back-to-back frames.
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            idx_d   = 3'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Tick is registered alongside the counter: it is high in the cycle
   // after an edge that loads the counter with its last value.
   always_comb begin
      tick_d = 1'b0;
      if ((state_d != ST_IDLE) && (cnt_d == CNT_LAST)) begin
         tick_d = 1'b1;
      end else begin
         tick_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
         shift_q <= 8'h00;
         idx_q   <= 3'd0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         tick_q  <= tick_d;
      end
   end

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign baud_tick = tick_q;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

   localparam int CLK_FREQ = 80;
   localparam int BAUD     = 10;
   localparam int DIV      = CLK_FREQ / BAUD;
   localparam int FRAME    = 10 * DIV;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] data_in;
   logic       tx;
   logic       busy;
   logic       baud_tick;

   int tests;
   int fails;

   // reference model: a frame is described only by its start cycle and byte
   int         k;
   logic       m_active;
   int         m_start;
   logic [7:0] m_byte;

   uart_tx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .data_in   (data_in),
      .tx        (tx),
      .busy      (busy),
      .baud_tick (baud_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       e;
      logic [7:0] d;
      logic [2:0] exp;   // {tx, busy, baud_tick}
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, k, act, exp);
      end
   endtask

   function automatic logic [2:0] model_out();
      logic [9:0] frame;
      int off;
      if (!m_active) return 3'b100;
      off   = k - m_start;
      frame = {1'b1, m_byte, 1'b0};
      return {frame[off / DIV], 1'b1, ((off % DIV) == DIV - 1)};
   endfunction

   // one clock: drive, edge, update model, compare
   task automatic step(input logic r, input logic e, input logic [7:0] d);
      rst = r; en = e; data_in = d;
      @(posedge clk);
      k++;
      if (r) begin
         m_active = 1'b0;
      end else if (m_active) begin
         if (k - m_start == FRAME) m_active = 1'b0;
      end else if (e) begin
         m_active = 1'b1;
         m_start  = k;
         m_byte   = d;
      end
      #1;
      check("model", {29'd0, tx, busy, baud_tick}, {29'd0, model_out()});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
   endtask

   // send one byte, optionally re-requesting with 8'hFF at offset ign
   task automatic run_frame(input logic [7:0] b, input int ign,
                            output logic [7:0] got, output int blen, output int nt);
      int off;
      got = 8'h00; blen = 0; nt = 0;
      step(1'b0, 1'b1, b);
      if (busy) blen++;
      for (off = 1; off < 2 * FRAME; off++) begin
         if (off == ign) step(1'b0, 1'b1, 8'hFF);
         else            step(1'b0, 1'b0, 8'($urandom));
         if (!busy) break;
         blen++;
         if (baud_tick) nt++;
         if ((off % DIV) == DIV / 2 && off / DIV >= 1 && off / DIV <= 8)
            got[off / DIV - 1] = tx;
      end
   endtask

   task automatic frame_test(input string name, input logic [7:0] b, input int ign);
      logic [7:0] got;
      int blen, nt;
      run_frame(b, ign, got, blen, nt);
      check({name, "_byte"}, {24'd0, got}, {24'd0, b});
      check({name, "_busy_len"}, blen, FRAME);
      check({name, "_ticks"}, nt, 10);
   endtask

   initial begin
      int busy_seen, idle_run, low_run, frames, gaps_bad, lows_bad;
      logic prev_busy, prev_tx;
      tests = 0; fails = 0; k = 0;
      m_active = 1'b0; m_start = 0; m_byte = 8'h00;
      rst = 1'b1; en = 1'b0; data_in = 8'h00;

      // vectors: {rst, en, data, {tx,busy,tick}}
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 3'b100};
      tbl[1]  = '{1'b1, 1'b1, 8'h5A, 3'b100};  // reset beats en
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 3'b100};
      tbl[3]  = '{1'b0, 1'b1, 8'hA5, 3'b010};  // accepted, start bit
      tbl[4]  = '{1'b0, 1'b1, 8'hFF, 3'b010};  // ignored while busy
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 3'b010};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 3'b010};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 3'b010};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 3'b010};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 3'b010};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 3'b011};  // last start-bit cycle
      tbl[11] = '{1'b0, 1'b0, 8'h00, 3'b110};  // bit0 of A5 = 1
      tbl[12] = '{1'b1, 1'b0, 8'h00, 3'b100};  // reset mid-frame
      tbl[13] = '{1'b0, 1'b1, 8'h3C, 3'b010};
      tbl[14] = '{1'b1, 1'b1, 8'h3C, 3'b100};

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].d);
         check($sformatf("vec%0d", i), {29'd0, tx, busy, baud_tick}, {29'd0, tbl[i].exp});
      end

      // reset held, then long idle
      step(1'b1, 1'b0, 8'h00); step(1'b1, 1'b0, 8'h00); step(1'b1, 1'b0, 8'h00);
      busy_seen = 0;
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (!tx || busy) busy_seen++;
      end
      check("reset_idle", busy_seen, 0);

      frame_test("a5", 8'hA5, -1);
      idle(40);
      frame_test("3c", 8'h3C, -1);
      idle(5);

      // request during data bit 3 is ignored, no second frame follows
      frame_test("ign", 8'hA5, 4 * DIV + 3);
      busy_seen = 0;
      for (int i = 0; i < 3 * DIV; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (busy) busy_seen++;
      end
      check("ign_no_second", busy_seen, 0);

      // reset during data bit 4
      step(1'b0, 1'b1, 8'hC3);
      for (int i = 1; i < 5 * DIV + 2; i++) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      check("midrst", {30'd0, tx, busy}, 32'd2);
      idle(3);
      frame_test("55", 8'h55, -1);

      // en held high: one idle cycle between frames, start+data low run 9*DIV
      idle(2);
      prev_busy = 1'b0; prev_tx = 1'b1;
      idle_run = 0; low_run = 0; frames = 0; gaps_bad = 0; lows_bad = 0;
      for (int i = 0; i < 3 * (FRAME + 1); i++) begin
         step(1'b0, 1'b1, 8'h00);
         if (busy && !prev_busy) begin
            if (frames > 0 && idle_run != 1) gaps_bad++;
            frames++;
            idle_run = 0;
         end
         if (!busy) idle_run++;
         if (!tx) low_run++;
         if (tx && !prev_tx) begin
            if (low_run != 9 * DIV) lows_bad++;
            low_run = 0;
         end
         prev_busy = busy; prev_tx = tx;
      end
      check("cont_frames", frames, 3);
      check("cont_gap", gaps_bad, 0);
      check("cont_low_run", lows_bad, 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0), 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
